// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte-stream requesters.
// Grants are held per packet; an optional header byte (HDR_BASE + id) precedes each packet.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter bit          HDR_EN      = 1'b1,
    parameter logic [7:0]  HDR_BASE    = 8'hF0,
    parameter int unsigned ACK_TIMEOUT = 4,
    localparam int unsigned IdW        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_start_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_busy_i,
    output logic                 grant_valid_o,
    output logic [IdW-1:0]       grant_id_o
);

    localparam logic [3:0] TimeoutLast = 4'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StWaitAck,
        StWaitDone
    } state_e;

    state_e               state_q, state_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [IdW-1:0]       grant_id_q, grant_id_d;
    logic [IdW-1:0]       rr_q, rr_d;
    logic                 last_q, last_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;

    logic [7:0]           req_bytes [NUM_REQ];
    logic                 pick_found;
    logic [IdW-1:0]       pick_id;
    logic [IdW-1:0]       scan_idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign req_bytes[i] = req_data_i[8*i +: 8];
    end

    // Round-robin pick: first scan from rr_q upward, then wrap to the indices below it.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = IdW'(i);
            if (!pick_found && scan_idx >= rr_q && req_valid_i[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = IdW'(i);
            if (!pick_found && scan_idx < rr_q && req_valid_i[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        rr_d          = rr_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        req_ready_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_id;
                    last_d        = 1'b0;
                    state_d       = HDR_EN ? StHdr : StData;
                end
            end
            StHdr: begin
                if (!tx_busy_i) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = HDR_BASE + 8'(grant_id_q);
                    cnt_d      = '0;
                    state_d    = StWaitAck;
                end
            end
            StData: begin
                if (req_valid_i[grant_id_q] && !tx_busy_i) begin
                    tx_start_d              = 1'b1;
                    tx_data_d               = req_bytes[grant_id_q];
                    req_ready_d[grant_id_q] = 1'b1;
                    last_d                  = req_last_i[grant_id_q];
                    cnt_d                   = '0;
                    state_d                 = StWaitAck;
                end
            end
            StWaitAck: begin
                // A transmitter that never acknowledges must not stall the grant forever.
                if (tx_busy_i || cnt_q == TimeoutLast) begin
                    state_d = StWaitDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWaitDone: begin
                if (!tx_busy_i) begin
                    if (last_q) begin
                        grant_valid_d = 1'b0;
                        rr_d          = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0
                                                                          : grant_id_q + IdW'(1);
                        state_d       = StIdle;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_q          <= '0;
            last_q        <= 1'b0;
            cnt_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            req_ready_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_q          <= rr_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            req_ready_q   <= req_ready_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign tx_start_o    = tx_start_q;
    assign tx_data_o     = tx_data_q;
    assign grant_valid_o = grant_valid_q;
    assign grant_id_o    = grant_id_q;

endmodule
